// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX/RX blocks.
// Holds the arbiter state enum, byte width and baud divider.
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int UART_BAUD_DIV = 434;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ACCEPT,
        ARB_SEND,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin search over req, starting at ptr.
// Ports: req, ptr in; pick_onehot, pick_idx, pick_any out.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               pick_any
);

    localparam int SW = PTR_W + 1;

    logic [SW-1:0]    sum;
    logic [PTR_W-1:0] pos;

    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        sum         = '0;
        pos         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit keeps ptr+k from overflowing before the wrap.
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            pos = sum[PTR_W-1:0];
            if (!pick_any && req[pos]) begin
                pick_any         = 1'b1;
                pick_onehot[pos] = 1'b1;
                pick_idx         = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin message arbiter in front of one UART transmitter.
// Ports: clk, rst; req_valid/req_data/req_last in, req_ready out;
// grant out; tx_data, tx_data_en out; tx_busy in; timeout_err out.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_data_en,
    input  logic                           tx_busy,
    output logic                           timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    uart_arb_state_t        state, state_n;
    logic [PTR_W-1:0]       ptr_r, ptr_n;
    logic [PTR_W-1:0]       gidx_r, gidx_n;
    logic [NUM_REQ-1:0]     grant_r, grant_n;
    logic [UART_BYTE_W-1:0] data_r, data_n;
    logic                   last_r, last_n;
    logic [TMR_W-1:0]       timer_r, timer_n;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;

    logic [UART_BYTE_W-1:0] sel_data;
    logic                   sel_last;
    logic                   sel_valid;
    logic                   byte_done;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req         (req_valid),
        .ptr         (ptr_r),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    always_comb begin
        sel_data  = '0;
        sel_last  = req_last[gidx_r];
        sel_valid = req_valid[gidx_r];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_r == PTR_W'(i)) begin
                sel_data = req_data[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr_r;
        gidx_n      = gidx_r;
        grant_n     = grant_r;
        data_n      = data_r;
        last_n      = last_r;
        timer_n     = timer_r;
        byte_done   = 1'b0;
        timeout_err = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any && !tx_busy) begin
                    grant_n = pick_onehot;
                    gidx_n  = pick_idx;
                    state_n = ARB_ACCEPT;
                end
            end
            ARB_ACCEPT: begin
                if (sel_valid) begin
                    data_n  = sel_data;
                    last_n  = sel_last;
                    state_n = ARB_SEND;
                end
            end
            ARB_SEND: begin
                timer_n = '0;
                state_n = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = ARB_WAIT_DONE;
                end else if (timer_r == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never started: drop the byte, keep the grant.
                    timeout_err = 1'b1;
                    byte_done   = 1'b1;
                end else begin
                    timer_n = timer_r + TMR_W'(1);
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
        if (byte_done) begin
            if (last_r) begin
                ptr_n   = (gidx_r == PTR_W'(NUM_REQ - 1)) ?
                          '0 : gidx_r + PTR_W'(1);
                grant_n = '0;
                state_n = ARB_IDLE;
            end else begin
                state_n = ARB_ACCEPT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            ptr_r   <= '0;
            gidx_r  <= '0;
            grant_r <= '0;
            data_r  <= '0;
            last_r  <= 1'b0;
            timer_r <= '0;
        end else begin
            state   <= state_n;
            ptr_r   <= ptr_n;
            gidx_r  <= gidx_n;
            grant_r <= grant_n;
            data_r  <= data_n;
            last_r  <= last_n;
            timer_r <= timer_n;
        end
    end

    assign grant      = grant_r;
    assign req_ready  = (state == ARB_ACCEPT) ? grant_r : '0;
    assign tx_data    = data_r;
    assign tx_data_en = (state == ARB_SEND);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench with a per-cycle reference model
// and a simple transmitter stand-in driving tx_busy.
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    localparam int P_ARB   = 0;
    localparam int P_BYTE  = 1;
    localparam int P_PULSE = 2;
    localparam int P_RISE  = 3;
    localparam int P_FALL  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_data_en;
    logic           tx_busy = 1'b0;
    logic           timeout_err;

    uart_tx_arb #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_data_en  (tx_data_en),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [8:0] rq [N][$];
    int         glog[$];
    int         xlog[$];
    logic [7:0] rxlog[$];
    int         to_cnt = 0;
    int         to_delta = 0;
    int         en_cyc = 0;
    int         cyc = 0;
    bit         armed = 1'b0;
    logic [N-1:0] prev_grant = '0;

    logic [N-1:0] pend_xfer = '0;
    bit           pend_en = 1'b0;
    bit           pend_rst = 1'b0;

    int bmode = 0;
    int frame_len = 12;
    int bcnt = 0;

    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_phase = P_ARB;
    logic [7:0] m_data = 8'h00;
    bit         m_last = 1'b0;
    int         m_since = 0;

    always @(negedge clk) begin
        logic [N-1:0] e_grant;
        bit           e_to;
        bit           done;
        if (armed) begin
            cyc++;
            e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            e_to = (m_phase == P_RISE) && !tx_busy && (m_since == TO);
            chk("grant", 32'(grant), 32'(e_grant));
            chk("req_ready", 32'(req_ready),
                32'((m_phase == P_BYTE) ? e_grant : '0));
            chk("tx_data_en", 32'(tx_data_en), 32'(m_phase == P_PULSE));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("timeout_err", 32'(timeout_err), 32'(e_to));

            if (grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < N; i++) begin
                    if (grant[i]) glog.push_back(i);
                end
            end
            prev_grant = grant;
            if (tx_data_en) begin
                rxlog.push_back(tx_data);
                en_cyc = cyc;
            end
            if (timeout_err) begin
                to_cnt++;
                to_delta = cyc - en_cyc;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) xlog.push_back(i);
            end
            pend_xfer = req_valid & req_ready;
            pend_en   = tx_data_en;
            pend_rst  = rst;

            done = 1'b0;
            if (rst) begin
                m_owner = -1;
                m_ptr   = 0;
                m_phase = P_ARB;
                m_data  = 8'h00;
                m_last  = 1'b0;
                m_since = 0;
            end else begin
                case (m_phase)
                    P_ARB: begin
                        if (req_valid != '0 && !tx_busy) begin
                            for (int k = N - 1; k >= 0; k--) begin
                                if (req_valid[(m_ptr + k) % N])
                                    m_owner = (m_ptr + k) % N;
                            end
                            m_phase = P_BYTE;
                        end
                    end
                    P_BYTE: begin
                        if (req_valid[m_owner]) begin
                            m_data  = req_data[m_owner*8 +: 8];
                            m_last  = req_last[m_owner];
                            m_phase = P_PULSE;
                        end
                    end
                    P_PULSE: begin
                        m_phase = P_RISE;
                        m_since = 1;
                    end
                    P_RISE: begin
                        if (tx_busy) m_phase = P_FALL;
                        else if (m_since == TO) done = 1'b1;
                        else m_since++;
                    end
                    default: begin
                        if (!tx_busy) done = 1'b1;
                    end
                endcase
                if (done) begin
                    if (m_last) begin
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                        m_phase = P_ARB;
                    end else begin
                        m_phase = P_BYTE;
                    end
                end
            end
        end
    end

    task automatic drive();
        logic [8:0] head;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) begin
                head = rq[i][0];
                req_data[i*8 +: 8] = head[7:0];
                req_last[i] = head[8];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_rst) begin
            bcnt = 0;
            tx_busy = (bmode == 2);
        end else if (bmode == 2) begin
            tx_busy = 1'b1;
        end else if (bmode == 1) begin
            tx_busy = 1'b0;
        end else if (pend_en) begin
            tx_busy = 1'b1;
            bcnt = frame_len;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!pend_rst && pend_xfer[i] && rq[i].size() > 0)
                void'(rq[i].pop_front());
        end
        drive();
        pend_xfer = '0;
        pend_en = 1'b0;
        pend_rst = 1'b0;
    endtask

    task automatic reset_dut();
        for (int i = 0; i < N; i++) rq[i].delete();
        drive();
        rst = 1'b1;
        step();
        armed = 1'b1;
        step();
        rst = 1'b0;
        glog.delete();
        xlog.delete();
        rxlog.delete();
        to_cnt = 0;
        to_delta = 0;
    endtask

    task automatic run_idle(input int budget);
        bit idle;
        int n;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            step();
            n++;
            idle = (grant == '0) && !tx_busy;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) idle = 1'b0;
            end
        end
        if (!idle) begin
            n_run++;
            n_fail++;
            $display("FAIL wait_idle: not idle after %0d cycles", budget);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_en", 32'(tx_data_en), 0);
        chk("rst_timeout", 32'(timeout_err), 0);

        // single message, then ptr moved to 1
        frame_len = 12;
        rq[0].push_back({1'b1, 8'h42});
        drive();
        run_idle(2000);
        chk("single_rx_n", rxlog.size(), 1);
        if (rxlog.size() > 0) chk("single_rx0", 32'(rxlog[0]), 32'h42);
        chk("single_grant0", glog.size() > 0 ? glog[0] : -1, 0);
        chk("single_idle", 32'(grant), 0);
        rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h22});
        drive();
        run_idle(2000);
        chk("ptr_order_n", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("ptr_order1", glog[1], 1);
            chk("ptr_order2", glog[2], 0);
        end

        // contention
        reset_dut();
        rq[0].push_back({1'b0, 8'h42});
        rq[0].push_back({1'b1, 8'h6F});
        rq[2].push_back({1'b1, 8'h55});
        drive();
        run_idle(2000);
        chk("cont_rx_n", rxlog.size(), 3);
        if (rxlog.size() == 3) begin
            chk("cont_rx0", 32'(rxlog[0]), 32'h42);
            chk("cont_rx1", 32'(rxlog[1]), 32'h6F);
            chk("cont_rx2", 32'(rxlog[2]), 32'h55);
        end
        chk("cont_xfer_n", xlog.size(), 3);
        if (xlog.size() == 3) chk("cont_xfer2", xlog[2], 2);

        // round-robin wrap
        reset_dut();
        rq[0].push_back({1'b1, 8'hA0});
        rq[0].push_back({1'b1, 8'hA4});
        rq[1].push_back({1'b1, 8'hA1});
        rq[1].push_back({1'b1, 8'hA5});
        rq[2].push_back({1'b1, 8'hA2});
        rq[3].push_back({1'b1, 8'hA3});
        drive();
        run_idle(3000);
        chk("wrap_n", glog.size(), 6);
        if (glog.size() == 6) begin
            chk("wrap3", glog[3], 3);
            chk("wrap4", glog[4], 0);
            chk("wrap5", glog[5], 1);
        end
        if (rxlog.size() == 6) chk("wrap_rx5", 32'(rxlog[5]), 32'hA5);

        // timeout, grant kept across the abandoned byte
        reset_dut();
        bmode = 1;
        rq[1].push_back({1'b0, 8'hA5});
        rq[1].push_back({1'b1, 8'h3C});
        drive();
        run_idle(500);
        chk("to_cnt", to_cnt, 2);
        chk("to_delta", to_delta, 8);
        chk("to_grants", glog.size(), 1);
        chk("to_xfers", xlog.size(), 2);
        chk("to_rx_n", rxlog.size(), 2);
        if (rxlog.size() == 2) chk("to_rx1", 32'(rxlog[1]), 32'h3C);
        bmode = 0;

        // busy at start blocks arbitration
        reset_dut();
        bmode = 2;
        tx_busy = 1'b1;
        rq[1].push_back({1'b1, 8'h77});
        drive();
        for (int i = 0; i < 10; i++) step();
        chk("busy_hold_grant", 32'(grant), 0);
        bmode = 0;
        tx_busy = 1'b0;
        step();
        chk("busy_release_grant", 32'(grant), 32'h2);
        run_idle(2000);
        if (rxlog.size() == 1) chk("busy_rx0", 32'(rxlog[0]), 32'h77);

        // reset in the middle of a long frame
        reset_dut();
        frame_len = 4340;
        rq[0].push_back({1'b1, 8'h6F});
        drive();
        for (int i = 0; i < 20 && rxlog.size() == 0; i++) step();
        for (int i = 0; i < 2000; i++) step();
        chk("mid_grant_held", 32'(grant), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_tx_en", 32'(tx_data_en), 0);
        chk("mid_rst_timeout", 32'(timeout_err), 0);
        frame_len = 20;
        rq[0].push_back({1'b1, 8'h6F});
        drive();
        run_idle(2000);
        chk("mid_rx_n", rxlog.size(), 2);
        if (rxlog.size() == 2) chk("mid_rx1", 32'(rxlog[1]), 32'h6F);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
